// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a req/ack
// data-memory transaction with byte-lane steering, load extension and stall.
module mem_lsu #(
   parameter int WIDTH_D = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_t2,
   input  logic               mem_w_t2,
   input  logic [1:0]         size_t2,
   input  logic               unsigned_t2,
   input  logic [WIDTH_D-1:0] alu_out_t,
   input  logic [WIDTH_D-1:0] rt_data_t,
   output logic               dm_req,
   output logic               dm_we,
   output logic [WIDTH_D-1:0] dm_addr,
   output logic [3:0]         dm_be,
   output logic [WIDTH_D-1:0] dm_wdata,
   input  logic               dm_ack,
   input  logic [WIDTH_D-1:0] dm_rdata,
   output logic [WIDTH_D-1:0] memd_out,
   output logic               stall_ctrl_t2,
   output logic               misalign_err,
   output logic               timeout_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] off);
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = off[0];
         default: m = |off;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] rt);
      logic [31:0] wd;
      case (size)
         2'b00:   wd = {4{rt[7:0]}};
         2'b01:   wd = {2{rt[15:0]}};
         default: wd = rt;
      endcase
      return wd;
   endfunction

   function automatic logic [31:0] load_f(input logic [1:0] size, input logic uns,
                                          input logic [1:0] off, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] v;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   v = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   v = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: v = rd;
      endcase
      return v;
   endfunction

   state_t              state_r, state_s;
   logic [CW-1:0]       cnt_r, cnt_s, cnt_inc_s;
   logic [1:0]          size_r, size_s;
   logic                uns_r, uns_s;
   logic [1:0]          off_r, off_s;
   logic                req_s, we_s, mis_s, to_s;
   logic [WIDTH_D-1:0]  addr_s, wdata_s, memd_s;
   logic [3:0]          be_s;
   logic                valid_s, misalign_s;

   assign valid_s    = mem_r_t2 | mem_w_t2;
   assign misalign_s = misalign_f(size_t2, alu_out_t[1:0]);
   assign cnt_inc_s  = cnt_r + CW'(1);

   // Stall while a request is being launched or is outstanding; forced low in reset.
   assign stall_ctrl_t2 = ~rst & (((state_r == S_IDLE) & valid_s & ~misalign_s)
                                  | (state_r == S_WAIT));

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      size_s  = size_r;
      uns_s   = uns_r;
      off_s   = off_r;
      req_s   = dm_req;
      we_s    = dm_we;
      addr_s  = dm_addr;
      be_s    = dm_be;
      wdata_s = dm_wdata;
      memd_s  = memd_out;
      mis_s   = 1'b0;
      to_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (valid_s && misalign_s) begin
               mis_s = 1'b1;
               if (!mem_w_t2) begin
                  memd_s = '0;
               end else begin
                  memd_s = memd_out;
               end
            end else if (valid_s) begin
               req_s   = 1'b1;
               we_s    = mem_w_t2;
               addr_s  = {alu_out_t[WIDTH_D-1:2], 2'b00};
               be_s    = be_f(size_t2, alu_out_t[1:0]);
               wdata_s = wdata_f(size_t2, rt_data_t);
               size_s  = size_t2;
               uns_s   = unsigned_t2;
               off_s   = alu_out_t[1:0];
               cnt_s   = '0;
               state_s = S_WAIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (dm_ack) begin
               req_s   = 1'b0;
               state_s = S_DONE;
               if (!dm_we) begin
                  memd_s = load_f(size_r, uns_r, off_r, dm_rdata);
               end else begin
                  memd_s = memd_out;
               end
            end else if (cnt_inc_s == CW'(TIMEOUT)) begin
               cnt_s   = cnt_inc_s;
               req_s   = 1'b0;
               to_s    = 1'b1;
               state_s = S_DONE;
               if (!dm_we) begin
                  memd_s = '0;
               end else begin
                  memd_s = memd_out;
               end
            end else begin
               cnt_s = cnt_inc_s;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            req_s   = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

   // State, latched access fields and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         cnt_r        <= '0;
         size_r       <= 2'b00;
         uns_r        <= 1'b0;
         off_r        <= 2'b00;
         dm_req       <= 1'b0;
         dm_we        <= 1'b0;
         dm_addr      <= '0;
         dm_be        <= 4'b0000;
         dm_wdata     <= '0;
         memd_out     <= '0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         size_r       <= size_s;
         uns_r        <= uns_s;
         off_r        <= off_s;
         dm_req       <= req_s;
         dm_we        <= we_s;
         dm_addr      <= addr_s;
         dm_be        <= be_s;
         dm_wdata     <= wdata_s;
         memd_out     <= memd_s;
         misalign_err <= mis_s;
         timeout_err  <= to_s;
      end
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the 5-stage pipeline CPU. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns EX/MEM load/store controls into a request/acknowledge transaction on the data-memory port, and handles byte-lane steering and sign/zero extension. While an access is outstanding it stalls the pipeline, and it delivers the aligned load result as `memd_out` to MEM/WB.

## Interface
Parameters:
- `WIDTH_D`, 32: data/address width. Only 32 is supported (4 byte lanes).
- `TIMEOUT`, 15: maximum number of WAIT cycles without `dm_ack` before the access is abandoned. Legal range is ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_t2`  in  1  load request from EX/MEM.
- `mem_w_t2`  in  1  store request from EX/MEM; has priority if both `mem_r_t2` and `mem_w_t2` are high.
- `size_t2`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `unsigned_t2`  in  1  load zero-extends when 1, sign-extends when 0.
- `alu_out_t`  in  WIDTH_D  byte address.
- `rt_data_t`  in  WIDTH_D  store data (right-justified).
- `dm_req`  out  1  data-memory request, registered.
- `dm_we`  out  1  1 = write, registered.
- `dm_addr`  out  WIDTH_D  word address; `dm_addr[1:0]` is always 00.
- `dm_be`  out  4  byte enables; lane i = bits [8i+7:8i].
- `dm_wdata`  out  WIDTH_D  lane-replicated store data.
- `dm_ack`  in  1  memory completion; `dm_rdata` is valid in the same cycle.
- `dm_rdata`  in  WIDTH_D  raw read word.
- `memd_out`  out  WIDTH_D  formatted load data to MEM/WB, registered.
- `stall_ctrl_t2`  out  1  stall request to the hazard unit, combinational.
- `misalign_err`  out  1  one-cycle registered pulse.
- `timeout_err`  out  1  one-cycle registered pulse.

## Operation
- FSM states are IDLE, WAIT and DONE. Reset state is IDLE.
- **IDLE, access valid** (`mem_r_t2 | mem_w_t2`) and aligned:
  - Register `dm_req`=1, `dm_we`, `dm_addr`={addr[31:2],2'b00}, `dm_be` and `dm_wdata`.
  - Latch `size`, `unsigned` and `addr[1:0]` internally.
  - Clear the wait counter and go to WAIT.
- **Alignment rules:** a half-word access with addr[0]=1 is misaligned; a word access with addr[1:0]≠00 is misaligned.
- **IDLE, access misaligned:**
  - No request is issued and the state stays IDLE.
  - `misalign_err` pulses in the next cycle.
  - For a load, `memd_out`←0. A store is dropped.
- **IDLE, no access:** `memd_out` holds.
- **Byte enables:**
  - byte: `dm_be` = 0001<<addr[1:0].
  - half: `dm_be` = 0011 if addr[1]=0, else 1100.
  - word: `dm_be` = 1111.
- **Store data:**
  - byte: `dm_wdata` = {4{rt[7:0]}}.
  - half: `dm_wdata` = {2{rt[15:0]}}.
  - word: `dm_wdata` = rt.
- **WAIT:**
  - If `dm_ack`=1:
    - `dm_req`←0.
    - For a load, `memd_out`← the selected lane of `dm_rdata`, extended per the latched `unsigned`.
    - For a store, `memd_out` holds.
    - Go to DONE.
  - If `dm_ack`=0: the counter increments. When the counter reaches TIMEOUT:
    - `dm_req`←0 and go to DONE.
    - `timeout_err` pulses.
    - For a load, `memd_out`←0.
- **DONE:** one cycle, then unconditionally return to IDLE. `dm_ack` is ignored in IDLE and DONE.
- **Stall:** `stall_ctrl_t2` = (IDLE & valid & aligned) | WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle and MEM/WB captures `memd_out` then.
- **Upstream contract:** EX/MEM holds its outputs stable while `stall_ctrl_t2`=1.
- **Reset values:** all outputs, the counter and the latched fields are 0, and the state is IDLE. Reset asserted mid-WAIT drops `dm_req` immediately (asynchronously); the aborted access is not replayed.

## Timing
- Access presented in cycle 0 (IDLE) → `dm_req` high from cycle 1 → `dm_ack` in cycle k (k≥1) → DONE in cycle k+1.
- `stall_ctrl_t2` is high in cycles 0..k.
- Minimum load-to-use through MEM is 2 stall cycles (ack in cycle 1).
- `memd_out` is valid from the start of DONE and is stable until the next completed load.
- A timeout completes with DONE in cycle TIMEOUT+1 when no ack arrives.
- A misaligned or non-memory instruction causes zero stall cycles.
- Back-to-back memory instructions: the second one is seen in IDLE the cycle after DONE.

## Test plan
- **Signed and unsigned byte load:** lb with addr 0x103, `unsigned`=0, ack in cycle 1 with rdata 0x80FF_1234 → `dm_be`=1000, `memd_out`=0xFFFF_FF80, `stall_ctrl_t2` high in cycles 0–1. Repeat with `unsigned`=1 → `memd_out`=0x0000_0080.
- **Half store:** sh with addr 0x102, rt 0x0000_ABCD → `dm_addr`=0x100, `dm_we`=1, `dm_be`=1100, `dm_wdata`=0xABCD_ABCD; `memd_out` unchanged.
- **Delayed word load:** lw with addr 0x200, ack in cycle 3, rdata 0xDEAD_BEEF → stall in cycles 0–3, DONE in cycle 4, `memd_out`=0xDEAD_BEEF.
- **Misaligned word load:** lw with addr 0x201 → `dm_req` never rises, `misalign_err` pulses in cycle 1, `memd_out`=0, no stall.
- **Timeout:** lw with no ack and TIMEOUT=15 → `dm_req` drops and `timeout_err` pulses at the end of the 15th WAIT cycle, `memd_out`=0, FSM back in IDLE two cycles later.
- **Reset mid-WAIT:** assert `rst` in WAIT → `dm_req`, `stall_ctrl_t2` and `memd_out` are 0 immediately. A later ack is ignored. After `rst` is released, a new lh with addr 0x002 and rdata 0x7FFF_0000 → `memd_out`=0x0000_7FFF.
